// File: rtl/imm_ext_pipe_pkg.sv
// Immediate-extension mode encodings and constants, shared by the extender,
// the decoder and the control unit.
package ext_pkg;

   typedef enum logic [1:0] {
      EXT_ZERO   = 2'b00,
      EXT_SIGN   = 2'b01,
      EXT_LUI    = 2'b10,
      EXT_BRANCH = 2'b11
   } ext_mode_t;

   // Branch offsets are word offsets, so they are scaled to bytes.
   localparam int EXT_BR_SHIFT = 2;

endpackage

// File: rtl/imm_ext_pipe_ext_core.sv
// Purely combinational immediate extender: maps (mode, imm) to an OUT_W-bit value.
module ext_core
   import ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  ext_mode_t          mode,
   input  logic [IN_W-1:0]    imm,
   output logic [OUT_W-1:0]   ext
);

   localparam int PAD_W = OUT_W - IN_W;

   logic [OUT_W-1:0] zext;
   logic [OUT_W-1:0] sext;

   assign zext = {{PAD_W{1'b0}}, imm};
   assign sext = {{PAD_W{imm[IN_W-1]}}, imm};

   always_comb begin
      ext = zext;
      case (mode)
         EXT_ZERO:   ext = zext;
         EXT_SIGN:   ext = sext;
         EXT_LUI:    ext = {imm, {PAD_W{1'b0}}};
         // Bits shifted beyond the top of the word are simply lost.
         EXT_BRANCH: ext = sext << EXT_BR_SHIFT;
      endcase
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender for the ID stage with valid/ready handshake and tag sideband.
// Define IMM_EXT_SKID_EN to add a one-entry skid register so in_ready comes from a flop.
module imm_ext_pipe
   import ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_mode,
   input  logic [IN_W-1:0]    in_imm,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_imm,
   output logic [TAG_W-1:0]   out_tag
);

   // Handshake: a word moves on any rising edge where valid & ready are both high;
   // valid, once raised, holds with its payload unchanged until that edge.

   if (OUT_W < IN_W + 2) begin : g_width_check
      $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
   end

   logic [OUT_W-1:0] ext_val;
   logic             in_fire;

   ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .mode (ext_mode_t'(in_mode)),
      .imm  (in_imm),
      .ext  (ext_val)
   );

`ifdef IMM_EXT_SKID_EN
   logic             skid_valid;
   logic [OUT_W-1:0] skid_imm;
   logic [TAG_W-1:0] skid_tag;
   logic             out_free;

   // Ready depends only on the skid flop (and reset), never on out_ready.
   assign in_ready = rst_n & ~skid_valid;
   assign in_fire  = in_valid & in_ready;
   assign out_free = ~out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_imm    <= '0;
         out_tag    <= '0;
         skid_valid <= 1'b0;
         skid_imm   <= '0;
         skid_tag   <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (out_free) begin
         // The skid word is older than anything on the input, so it goes first.
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_imm    <= skid_imm;
            out_tag    <= skid_tag;
            skid_valid <= 1'b0;
         end else if (in_fire) begin
            out_valid <= 1'b1;
            out_imm   <= ext_val;
            out_tag   <= in_tag;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (in_fire) begin
         skid_valid <= 1'b1;
         skid_imm   <= ext_val;
         skid_tag   <= in_tag;
      end
   end
`else
   assign in_ready = rst_n & (~out_valid | out_ready);
   assign in_fire  = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_imm   <= '0;
         out_tag   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_fire) begin
         out_valid <= 1'b1;
         out_imm   <= ext_val;
         out_tag   <= in_tag;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed mode cases, back-pressure, flush,
// reset, throughput and a randomized stream scored against an arithmetic model.
module tb_imm_ext_pipe;
   import ext_pkg::*;

   localparam int IN_W  = 16;
   localparam int OUT_W = 32;
   localparam int TAG_W = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               flush = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [1:0]         in_mode = 2'b00;
   logic [IN_W-1:0]    in_imm = '0;
   logic [TAG_W-1:0]   in_tag = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [OUT_W-1:0]   out_imm;
   logic [TAG_W-1:0]   out_tag;

   logic               s_in_valid = 1'b0;
   logic               s_in_ready;
   logic [1:0]         s_in_mode = 2'b00;
   logic [7:0]         s_in_imm = '0;
   logic [TAG_W-1:0]   s_in_tag = '0;
   logic               s_out_valid;
   logic               s_out_ready = 1'b1;
   logic [15:0]        s_out_imm;
   logic [TAG_W-1:0]   s_out_tag;

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;
   int n_out    = 0;

   logic [OUT_W+TAG_W-1:0] exp_q[$];
   int                     acc_q[$];

   logic                   st_pending = 1'b0;
   logic [OUT_W+TAG_W-1:0] st_word = '0;
   logic [0:5]             rdy_pat = 6'b100110;

   imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_imm    (in_imm),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_imm   (out_imm),
      .out_tag   (out_tag)
   );

   imm_ext_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(TAG_W)) dut_small (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (1'b0),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_mode   (s_in_mode),
      .in_imm    (s_in_imm),
      .in_tag    (s_in_tag),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_imm   (s_out_imm),
      .out_tag   (s_out_tag)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic longint ref_ext(input int in_w, input int out_w, input int mode,
                                      input longint imm);
      longint s;
      longint r;
      s = imm;
      if (imm >= (longint'(1) << (in_w - 1))) s = imm - (longint'(1) << in_w);
      case (mode)
         0:       r = imm;
         1:       r = s;
         2:       r = imm * (longint'(1) << (out_w - in_w));
         default: r = s * 4;
      endcase
      return r & ((longint'(1) << out_w) - 1);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [OUT_W+TAG_W-1:0] e;
      logic [OUT_W-1:0]       r;
      int                     a;
      cycle++;
      if (!rst_n) begin
         exp_q.delete();
         acc_q.delete();
         st_pending = 1'b0;
      end else begin
         if (st_pending && out_valid)
            check("stall_stable", {out_imm, out_tag}, st_word);
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               check("unexpected_out", {out_imm, out_tag}, 64'hDEAD);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               check("out_word", {out_imm, out_tag}, e);
               check("min_latency", 64'(cycle > a), 64'd1);
            end
         end
         st_pending = out_valid && !out_ready && !flush;
         st_word    = {out_imm, out_tag};
         if (flush) begin
            exp_q.delete();
            acc_q.delete();
         end else if (in_valid && in_ready) begin
            r = OUT_W'(ref_ext(IN_W, OUT_W, int'(in_mode), longint'(in_imm)));
            exp_q.push_back({r, in_tag});
            acc_q.push_back(cycle);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_one(input logic [1:0] m, input logic [IN_W-1:0] imm,
                           input logic [TAG_W-1:0] tag, input logic [OUT_W-1:0] exp);
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_mode   = m;
      in_imm    = imm;
      in_tag    = tag;
      @(negedge clk);
      check("mode_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("mode_latency", 64'(out_valid), 64'd1);
      check("mode_value", 64'(out_imm), 64'(exp));
   endtask

   task automatic run_stream(input int n, input int rdy_mode, input int gap_pct,
                             input int tag_base);
      int     sent;
      int     k;
      int     guard;
      logic   acc;
      sent  = 0;
      k     = 0;
      guard = 0;
      acc   = 1'b0;
      while (sent < n && guard < 20 * n + 50) begin
         @(posedge clk); #1;
         if (acc || !in_valid) begin
            if ($urandom_range(99, 0) >= gap_pct) begin
               in_valid = 1'b1;
               in_mode  = 2'($urandom_range(3, 0));
               in_imm   = IN_W'($urandom);
               in_tag   = TAG_W'(tag_base + sent);
            end else begin
               in_valid = 1'b0;
            end
         end
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = rdy_pat[k % 6];
            default: out_ready = 1'($urandom_range(1, 0));
         endcase
         k++;
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc) sent++;
         guard++;
      end
      check("stream_sent", 64'(sent), 64'(n));
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(negedge clk); #1;
         guard++;
      end
      check("stream_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic small_one(input logic [1:0] m, input logic [7:0] imm);
      @(posedge clk); #1;
      s_in_valid = 1'b1;
      s_in_mode  = m;
      s_in_imm   = imm;
      @(negedge clk);
      check("small_ready", 64'(s_in_ready), 64'd1);
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      @(negedge clk);
      check("small_valid", 64'(s_out_valid), 64'd1);
      check("small_value", 64'(s_out_imm), 64'(ref_ext(8, 16, int'(m), longint'(imm))));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int acc_n;
      int bub;
      int base_out;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_imm", 64'(out_imm), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_in_ready", 64'(in_ready), 64'd1);
      check("rel_out_valid", 64'(out_valid), 64'd0);

      // Mode cases with known answers.
      send_one(EXT_ZERO,   16'h8001, 8'h01, 32'h00008001);
      send_one(EXT_SIGN,   16'h8001, 8'h02, 32'hFFFF8001);
      send_one(EXT_LUI,    16'h8001, 8'h03, 32'h80010000);
      send_one(EXT_BRANCH, 16'hFFFF, 8'h04, 32'hFFFFFFFC);
      send_one(EXT_BRANCH, 16'h7FFF, 8'h05, 32'h0001FFFC);

      // Back-pressure with the fixed ready pattern, tags 1..6.
      run_stream(6, 1, 0, 1);

      // Flush while words are held and a new word is offered.
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_mode   = EXT_SIGN;
      in_imm    = IN_W'($urandom);
      in_tag    = 8'd20;
      @(negedge clk);
      check("flush_first_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_imm = IN_W'($urandom);
      in_tag = 8'd21;
      @(negedge clk);
`ifdef IMM_EXT_SKID_EN
      check("one_held_ready", 64'(in_ready), 64'd1);
`else
      check("one_held_ready", 64'(in_ready), 64'd0);
`endif
      @(posedge clk); #1;
      flush  = 1'b1;
      in_tag = 8'd9;
      @(negedge clk);
      check("two_held_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("flush_nothing_left", 64'(out_valid), 64'd0);

      // Flush on an empty pipe drops an offered word even though ready is high.
      @(posedge clk); #1;
      flush    = 1'b1;
      in_valid = 1'b1;
      in_tag   = 8'd10;
      @(negedge clk);
      check("flush_empty_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_drop_valid", 64'(out_valid), 64'd0);

      // Reset in the middle of a stalled stream.
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_mode   = EXT_LUI;
      in_imm    = 16'h1234;
      in_tag    = 8'd30;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_out_imm", 64'(out_imm), 64'd0);
      check("mid_rst_out_tag", 64'(out_tag), 64'd0);
      check("mid_rst_in_ready1", 64'(in_ready), 64'd1);
      run_stream(5, 0, 0, 40);

      // Throughput: 100 back-to-back words.
      @(posedge clk); #1;
      out_ready = 1'b1;
      acc_n    = 0;
      bub      = 0;
      base_out = n_out;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_mode  = 2'($urandom_range(3, 0));
         in_imm   = IN_W'($urandom);
         in_tag   = TAG_W'(i);
         @(negedge clk);
         if (in_valid && in_ready) acc_n++;
         if (i > 0 && !out_valid) bub++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk); #1;
      check("tp_accepted", 64'(acc_n), 64'd100);
      check("tp_bubbles", 64'(bub), 64'd0);
      check("tp_delivered", 64'(n_out - base_out), 64'd100);

      // Randomized traffic with random gaps and random back-pressure.
      run_stream(150, 2, 30, 100);

      // Narrow instance: IN_W=8, OUT_W=16.
      @(posedge clk); #1;
      s_in_valid = 1'b1;
      s_in_mode  = EXT_BRANCH;
      s_in_imm   = 8'h80;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      @(negedge clk);
      check("small_branch_80", 64'(s_out_imm), 64'h0000FE00);
      @(posedge clk); #1;
      s_in_valid = 1'b1;
      s_in_mode  = EXT_LUI;
      s_in_imm   = 8'h80;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      @(negedge clk);
      check("small_lui_80", 64'(s_out_imm), 64'h00008000);
      for (int i = 0; i < 8; i++)
         small_one(2'($urandom_range(3, 0)), 8'($urandom));

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
